rip_lsu: RTL and testbench

RIP_LSU -- requirements
Module: rip_lsu

---
 rtl/rip_common_pkg.sv | 107 ++++++++++
 rtl/rip_lsu_if.sv | 27 ++
 rtl/rip_lsu_extend.sv | 34 +++
 rtl/rip_lsu.sv | 189 ++++++++++++++++++
 tb/tb_rip_lsu.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/rip_common_pkg.sv
// rip_common: types shared across the RIP core.
//   inst_t      - raw 32-bit RV32 instruction viewed as R-type fields
//   lsu_op_t    - load/store access type handed from decode to the LSU
//   lsu_fault_t - LSU completion status
//   lsu_state_t - LSU control state
// Helper functions cover decode of inst_t onto lsu_op_t and the
// per-access alignment, byte-strobe and lane-replication rules.
package rip_common;

  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } inst_t;

  typedef enum logic [2:0] {
    LB  = 3'd0,
    LH  = 3'd1,
    LW  = 3'd2,
    LBU = 3'd3,
    LHU = 3'd4,
    SB  = 3'd5,
    SH  = 3'd6,
    SW  = 3'd7
  } lsu_op_t;

  typedef enum logic [1:0] {
    NONE     = 2'd0,
    MISALIGN = 2'd1,
    TIMEOUT  = 2'd2
  } lsu_fault_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } lsu_state_t;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  // Decode maps the opcode/funct3 fields of an inst_t onto the LSU op.
  // Reserved funct3 encodings fall back to a word access.
  function automatic lsu_op_t decode_lsu_op(input logic [6:0] opcode,
                                            input logic [2:0] funct3);
    lsu_op_t o;
    o = LW;
    if (opcode == OPC_STORE) begin
      case (funct3)
        3'd0:    o = SB;
        3'd1:    o = SH;
        default: o = SW;
      endcase
    end else begin
      case (funct3)
        3'd0:    o = LB;
        3'd1:    o = LH;
        3'd4:    o = LBU;
        3'd5:    o = LHU;
        default: o = LW;
      endcase
    end
    return o;
  endfunction

  function automatic logic is_store(input lsu_op_t o);
    return (o == SB) || (o == SH) || (o == SW);
  endfunction

  function automatic logic is_misaligned(input lsu_op_t o, input logic [1:0] off);
    logic m;
    case (o)
      LH, LHU, SH: m = off[0];
      LW, SW:      m = (off != 2'b00);
      default:     m = 1'b0;
    endcase
    return m;
  endfunction

  function automatic logic [3:0] lsu_wstrb(input lsu_op_t o, input logic [1:0] off);
    logic [3:0] s;
    case (o)
      SB:      s = 4'b0001 << off;
      SH:      s = 4'b0011 << off;
      SW:      s = 4'hF;
      default: s = 4'h0;
    endcase
    return s;
  endfunction

  // Sub-word stores replicate their data across every lane so the memory
  // only needs the strobes to pick the right bytes.
  function automatic logic [31:0] lsu_wdata(input lsu_op_t o, input logic [31:0] d);
    logic [31:0] w;
    case (o)
      SB:      w = {4{d[7:0]}};
      SH:      w = {2{d[15:0]}};
      SW:      w = d;
      default: w = 32'h0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/rip_lsu_if.sv
// rip_lsu_if: word-wide memory bus between the LSU and data memory.
//   mem_req/mem_ack  - request held until acknowledged
//   mem_we           - 1 for stores
//   mem_addr         - word-aligned byte address
//   mem_wstrb        - byte-lane write enables
//   mem_wdata        - store data (lane-replicated)
//   mem_rdata        - read word, valid with mem_ack
// master: LSU side; slave: memory side.
interface rip_lsu_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/rip_lsu_extend.sv
// rip_lsu_extend: combinational load-data extraction.
//   op_i     - access type
//   off_i    - byte offset within the word (addr[1:0])
//   word_i   - word returned by memory
//   result_o - selected byte/halfword, sign- or zero-extended;
//              full word for LW; zero for stores
module rip_lsu_extend
  import rip_common::*;
(
  input  lsu_op_t     op_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] word_i,
  output logic [31:0] result_o
);

  logic [7:0]  byte_w;
  logic [15:0] half_w;

  always_comb begin
    byte_w   = word_i[{off_i, 3'b000} +: 8];
    // Halfword loads are aligned, so only off_i[1] picks the half.
    half_w   = off_i[1] ? word_i[31:16] : word_i[15:0];
    result_o = 32'h0;
    case (op_i)
      LB:      result_o = {{24{byte_w[7]}}, byte_w};
      LBU:     result_o = {24'h0, byte_w};
      LH:      result_o = {{16{half_w[15]}}, half_w};
      LHU:     result_o = {16'h0, half_w};
      LW:      result_o = word_i;
      default: result_o = 32'h0;
    endcase
  end

endmodule

// File: rtl/rip_lsu.sv
// rip_lsu: load/store unit with a single outstanding memory access.
//   clk, rst_n        - clock, asynchronous active-low reset
//   start, op, addr,
//   wdata             - request pulse and its operands (taken in IDLE only)
//   busy              - high whenever not IDLE
//   done              - one-cycle completion pulse
//   rdata             - extended load result (valid with done)
//   fault, fault_cause- completion status (valid with done)
//   mem               - memory bus, master side
// Parameter BUS_TIMEOUT: ACCESS cycles without mem_ack before a TIMEOUT
// fault (1..255).
module rip_lsu
  import rip_common::*;
#(
  parameter int unsigned BUS_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  lsu_op_t     op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        fault,
  output lsu_fault_t  fault_cause,
  rip_lsu_if.master   mem
);

  localparam logic [7:0] CNT_LAST = 8'(BUS_TIMEOUT - 1);

  lsu_state_t  state_q, state_d;
  lsu_op_t     op_q, op_d;
  logic [1:0]  off_q, off_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [3:0]  mem_wstrb_q, mem_wstrb_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        fault_q, fault_d;
  lsu_fault_t  cause_q, cause_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] ext_word;

  logic take_req;
  logic req_mis;
  logic acc_timeout;

  assign take_req    = (state_q == S_IDLE) && start;
  assign req_mis     = is_misaligned(op, addr[1:0]);
  assign acc_timeout = (cnt_q == CNT_LAST);

  rip_lsu_extend u_extend (
    .op_i     (op_q),
    .off_i    (off_q),
    .word_i   (mem.mem_rdata),
    .result_o (ext_word)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = req_mis ? S_RESP : S_ACCESS;
      S_ACCESS: if (mem.mem_ack || acc_timeout) state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = (state_q != S_IDLE);
    done = (state_q == S_RESP);
  end

  // Datapath next-state: request capture, bus drive and completion status.
  always_comb begin
    op_d        = op_q;
    off_d       = off_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wstrb_d = mem_wstrb_q;
    mem_wdata_d = mem_wdata_q;
    fault_d     = fault_q;
    cause_d     = cause_q;
    rdata_d     = rdata_q;

    case (state_q)
      S_IDLE: begin
        if (take_req) begin
          op_d    = op;
          off_d   = addr[1:0];
          cnt_d   = 8'd0;
          rdata_d = 32'h0;
          if (req_mis) begin
            fault_d = 1'b1;
            cause_d = MISALIGN;
          end else begin
            fault_d     = 1'b0;
            cause_d     = NONE;
            mem_req_d   = 1'b1;
            mem_we_d    = is_store(op);
            mem_addr_d  = {addr[31:2], 2'b00};
            mem_wstrb_d = lsu_wstrb(op, addr[1:0]);
            mem_wdata_d = lsu_wdata(op, wdata);
          end
        end
      end
      S_ACCESS: begin
        if (mem.mem_ack || acc_timeout) begin
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          mem_addr_d  = 32'h0;
          mem_wstrb_d = 4'h0;
          mem_wdata_d = 32'h0;
          cnt_d       = 8'd0;
          // An ack in the final counted cycle still wins over the timeout.
          if (mem.mem_ack) begin
            fault_d = 1'b0;
            cause_d = NONE;
            rdata_d = is_store(op_q) ? 32'h0 : ext_word;
          end else begin
            fault_d = 1'b1;
            cause_d = TIMEOUT;
            rdata_d = 32'h0;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_RESP: begin
        fault_d = 1'b0;
        cause_d = NONE;
        rdata_d = 32'h0;
      end
      default: ;
    endcase
  end

  // Datapath registers; reset also clears the bus so mem_req drops at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q        <= LB;
      off_q       <= 2'b00;
      cnt_q       <= 8'd0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_wstrb_q <= 4'h0;
      mem_wdata_q <= 32'h0;
      fault_q     <= 1'b0;
      cause_q     <= NONE;
      rdata_q     <= 32'h0;
    end else begin
      op_q        <= op_d;
      off_q       <= off_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wstrb_q <= mem_wstrb_d;
      mem_wdata_q <= mem_wdata_d;
      fault_q     <= fault_d;
      cause_q     <= cause_d;
      rdata_q     <= rdata_d;
    end
  end

  assign mem.mem_req   = mem_req_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wstrb = mem_wstrb_q;
  assign mem.mem_wdata = mem_wdata_q;
  assign rdata         = rdata_q;
  assign fault         = fault_q;
  assign fault_cause   = cause_q;

endmodule

// File: tb/tb_rip_lsu.sv
// tb_rip_lsu: randomized and directed bench for rip_lsu with a
// behavioural access model.
module tb_rip_lsu;
  import rip_common::*;

  localparam int TO = 4;

  logic        clk;
  logic        rst_n;
  logic        start;
  lsu_op_t     op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] rdata;
  logic        fault;
  lsu_fault_t  fault_cause;

  int n_total;
  int n_bad;

  rip_lsu_if bus ();

  rip_lsu #(.BUS_TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .op          (op),
    .addr        (addr),
    .wdata       (wdata),
    .busy        (busy),
    .done        (done),
    .rdata       (rdata),
    .fault       (fault),
    .fault_cause (fault_cause),
    .mem         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---- reference model ----
  function automatic int unsigned m_size(lsu_op_t o);
    if (o == LH || o == LHU || o == SH) return 2;
    if (o == LW || o == SW) return 4;
    return 1;
  endfunction

  function automatic bit m_misaligned(lsu_op_t o, logic [31:0] a);
    return (a % m_size(o)) != 0;
  endfunction

  function automatic bit m_store(lsu_op_t o);
    return (o == SB || o == SH || o == SW);
  endfunction

  function automatic logic [31:0] m_load(lsu_op_t o, logic [31:0] a, logic [31:0] w);
    int unsigned sh;
    int unsigned b;
    int unsigned h;
    sh = 8 * (a % 4);
    b  = (w >> sh) & 32'hFF;
    h  = (w >> sh) & 32'hFFFF;
    case (o)
      LB:      return (b >= 128) ? b - 256 : b;
      LBU:     return b;
      LH:      return (h >= 32768) ? h - 65536 : h;
      LHU:     return h;
      LW:      return w;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [3:0] m_wstrb(lsu_op_t o, logic [31:0] a);
    int unsigned lanes;
    lanes = 0;
    if (m_store(o))
      for (int i = 0; i < int'(m_size(o)); i++) lanes = lanes + (1 << ((a % 4) + i));
    return 4'(lanes);
  endfunction

  function automatic logic [31:0] m_wdata(lsu_op_t o, logic [31:0] d);
    case (o)
      SB:      return (d & 32'hFF) * 32'h01010101;
      SH:      return (d & 32'hFFFF) * 32'h00010001;
      default: return d;
    endcase
  endfunction

  // One complete request. ack_at = ACCESS cycle carrying mem_ack (0 = never).
  // hammer adds extra start pulses while busy and in the done cycle.
  task automatic run_op(input lsu_op_t o, input logic [31:0] a, input logic [31:0] wd,
                        input int ack_at, input logic [31:0] word, input bit hammer);
    bit          mis;
    logic [31:0] exp_rd;
    int          exp_cause;
    mis = m_misaligned(o, a);
    check_eq("idle_busy", 32'(busy), 32'd0);
    start = 1'b1; op = o; addr = a; wdata = wd;
    tick();
    start = 1'b0;
    op    = lsu_op_t'($urandom_range(0, 7));
    addr  = $urandom;
    wdata = $urandom;
    if (!mis) begin
      for (int n = 1; n <= TO; n++) begin
        check_eq("acc_req", 32'(bus.mem_req), 32'd1);
        check_eq("acc_busy", 32'(busy), 32'd1);
        check_eq("acc_done", 32'(done), 32'd0);
        check_eq("acc_addr", bus.mem_addr, {a[31:2], 2'b00});
        check_eq("acc_we", 32'(bus.mem_we), 32'(m_store(o)));
        check_eq("acc_wstrb", 32'(bus.mem_wstrb), 32'(m_wstrb(o, a)));
        if (m_store(o)) check_eq("acc_wdata", bus.mem_wdata, m_wdata(o, wd));
        if (hammer && n == 1) start = 1'b1;
        if (n == ack_at) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = word;
        end
        tick();
        start         = 1'b0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = $urandom;
        if (n == ack_at) break;
      end
    end
    if (mis) begin
      exp_cause = int'(MISALIGN);
      exp_rd    = 32'h0;
    end else if (ack_at == 0) begin
      exp_cause = int'(TIMEOUT);
      exp_rd    = 32'h0;
    end else begin
      exp_cause = int'(NONE);
      exp_rd    = m_load(o, a, word);
    end
    check_eq("resp_done", 32'(done), 32'd1);
    check_eq("resp_req", 32'(bus.mem_req), 32'd0);
    check_eq("resp_fault", 32'(fault), 32'(exp_cause != int'(NONE)));
    check_eq("resp_cause", 32'(fault_cause), 32'(exp_cause));
    check_eq("resp_rdata", rdata, exp_rd);
    if (hammer) start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("post_done", 32'(done), 32'd0);
    check_eq("post_busy", 32'(busy), 32'd0);
    check_eq("post_req", 32'(bus.mem_req), 32'd0);
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    rst_n = 1'b0;
    start = 1'b0;
    op    = LB;
    addr  = 32'h0;
    wdata = 32'h0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'h0;
    #22;
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_req", 32'(bus.mem_req), 32'd0);
    check_eq("rst_we", 32'(bus.mem_we), 32'd0);
    check_eq("rst_wstrb", 32'(bus.mem_wstrb), 32'd0);
    check_eq("rst_addr", bus.mem_addr, 32'd0);
    check_eq("rst_wdata", bus.mem_wdata, 32'd0);
    check_eq("rst_rdata", rdata, 32'd0);
    check_eq("rst_fault", 32'(fault), 32'd0);
    check_eq("rst_cause", 32'(fault_cause), 32'(NONE));
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Directed cases
    run_op(LB,  32'h0000_1003, 32'h0,         1,  32'h8000_0000, 1'b0);
    run_op(SH,  32'h0000_2002, 32'h0000_BEEF, 2,  32'h1234_5678, 1'b0);
    run_op(LW,  32'h0000_3001, 32'h0,         1,  32'h0,         1'b0);
    run_op(LHU, 32'h0000_4000, 32'h0,         0,  32'h0,         1'b0);
    run_op(LH,  32'h0000_4002, 32'h0,         TO, 32'h8001_7FFF, 1'b0);
    run_op(SW,  32'h0000_5000, 32'hCAFE_F00D, 3,  32'h0,         1'b1);
    run_op(SB,  32'h0000_6001, 32'h0000_00A5, 1,  32'h0,         1'b0);

    // Ack outside ACCESS has no effect
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    check_eq("idle_ack_busy", 32'(busy), 32'd0);
    check_eq("idle_ack_done", 32'(done), 32'd0);

    // Randomized requests
    for (int i = 0; i < 80; i++) begin
      run_op(lsu_op_t'($urandom_range(0, 7)), $urandom, $urandom,
             int'($urandom_range(0, TO)), $urandom, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) tick();
    end

    // Reset asserted in ACCESS cycle 2
    start = 1'b1; op = LW; addr = 32'h0000_7000; wdata = 32'h0;
    tick();
    start = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_req", 32'(bus.mem_req), 32'd0);
    check_eq("arst_busy", 32'(busy), 32'd0);
    check_eq("arst_done", 32'(done), 32'd0);
    tick();
    check_eq("arst_done2", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run_op(LBU, 32'h0000_8002, 32'h0, 2, 32'h00C3_0000, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
